// File: rtl/spi_slave_responder.sv
// Mode-0 SPI target, oversampled on clk. Byte-wide TX/RX holding registers with
// valid/ready handshakes toward local logic; IDLE_BYTE is sent whenever TX runs dry.
module spi_slave_responder #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);

  localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_dly_q, cs_dly_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_W-1:0]      tx_shift_q, rx_shift_q;
  logic [DATA_W-1:0]      hold_data_q, rx_data_q;
  logic                   hold_valid_q, hold_valid_d;
  logic                   rx_valid_q, rx_overrun_q, tx_underrun_q;
  logic                   miso_q, miso_oe_q;

  // CS chain resets to "asserted" so a CS already low at reset release is not
  // mistaken for a new falling edge; a frame needs a genuine high-to-low transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic active, sck_ok, byte_done, tx_load, tx_wr, rx_accept;
  logic [DATA_W-1:0] load_byte, rx_byte;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_dly_q;
  assign sck_fall  = ~sck_s & sck_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  assign active    = (state_q == ACTIVE);
  assign sck_ok    = active & ~cs_rise;
  assign byte_done = sck_ok & sck_rise & (bit_cnt_q == LAST_BIT);
  assign tx_load   = (~active & cs_fall) | (sck_ok & sck_fall & (bit_cnt_q == '0));
  assign load_byte = hold_valid_q ? hold_data_q : IDLE_BYTE;
  assign rx_byte   = {rx_shift_q[DATA_W-2:0], mosi_s};
  assign tx_wr     = tx_valid_i & ~hold_valid_q;
  assign rx_accept = rx_valid_q & rx_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= IDLE_BYTE;
      rx_shift_q <= '0;
      miso_q     <= 1'b1;
      miso_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          miso_oe_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= ACTIVE;
            miso_oe_q  <= 1'b1;
            tx_shift_q <= load_byte;
            miso_q     <= load_byte[DATA_W-1];
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b1;
          end else if (sck_rise) begin
            rx_shift_q <= rx_byte;
            bit_cnt_q  <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
          end else if (sck_fall) begin
            if (bit_cnt_q == '0) begin
              tx_shift_q <= load_byte;
              miso_q     <= load_byte[DATA_W-1];
            end else begin
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
              miso_q     <= tx_shift_q[DATA_W-2];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A write landing in the same cycle as a load refills holding for the next byte.
  assign hold_valid_d = (hold_valid_q & ~tx_load) | tx_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      if (tx_wr) hold_data_q <= tx_data_i;
      tx_underrun_q <= tx_load & ~hold_valid_q;
      rx_overrun_q  <= byte_done & rx_valid_q & ~rx_ready_i;
      if (byte_done && (!rx_valid_q || rx_ready_i)) begin
        rx_data_q  <= rx_byte;
        rx_valid_q <= 1'b1;
      end else if (rx_accept) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = miso_oe_q;
  assign tx_ready_o    = ~hold_valid_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;
  assign busy_o        = active;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed + randomized bench for spi_slave_responder: a cycle-timed SPI master
// task drives frames; expected bytes and pulse counts come from a holding-register model.
module tb_spi_slave_responder;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          spi_clk, spi_cs, spi_mosi, spi_miso, spi_miso_oe;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;
  logic          rx_overrun, tx_underrun, busy;

  spi_slave_responder #(.DATA_W(DW), .SYNC_STAGES(SS), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk_i(spi_clk), .spi_cs_i(spi_cs), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso), .spi_miso_oe_o(spi_miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_overrun_o(rx_overrun), .tx_underrun_o(tx_underrun), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int und_cnt = 0, ovr_cnt = 0;
  logic [7:0] rx_q[$];

  // Passive monitor: counts pulses and logs every accepted RX byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_underrun) und_cnt++;
      if (rx_overrun)  ovr_cnt++;
      if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
  endtask

  logic [7:0] m_out[4];
  logic [7:0] m_in[4];

  // Mode-0 master, SCK = clk/8. CS is raised while SCK is still high after the
  // final bit, so the trailing SCK fall happens deselected.
  task automatic frame(input int nb, input int abort_at, input bit ack_last,
                       input bit txw_fall, input logic [7:0] txw_byte);
    int rises = 0;
    spi_cs = 1'b0;
    if (txw_fall) begin
      tick(SS); tx_data = txw_byte; tx_valid = 1'b1; tick(1); tx_valid = 1'b0; tick(6 - SS - 1);
    end else tick(6);
    for (int b = 0; b < nb; b++) begin
      for (int i = DW - 1; i >= 0; i--) begin
        if (rises > 0) spi_clk = 1'b0;
        spi_mosi = m_out[b][i];
        tick(4);
        m_in[b][i] = spi_miso;
        spi_clk = 1'b1;
        rises++;
        if (ack_last && b == nb - 1 && i == 0) begin
          tick(SS); rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(4 - SS - 1);
        end else tick(4);
        if (rises == abort_at) begin
          spi_cs = 1'b1;
          tick(SS + 2);
          check("abort_busy", busy, 0);
          check("abort_oe", spi_miso_oe, 0);
          spi_clk = 1'b0;
          tick(6);
          return;
        end
      end
    end
    spi_cs = 1'b1; tick(4); spi_clk = 1'b0; tick(6);
  endtask

  initial begin
    int u0, o0, q0, nb;
    logic       mdl_hv;
    logic [7:0] mdl_hd, exp_b;
    int         exp_und;

    spi_clk = 0; spi_cs = 1; spi_mosi = 0;
    tx_data = '0; tx_valid = 0; rx_ready = 0;

    // Reset values
    rst_n = 1'b0; tick(3);
    check("rst_miso", spi_miso, 1);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_txrdy", tx_ready, 1);
    check("rst_rxdata", rx_data, 0);
    check("rst_rxvld", rx_valid, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_und", tx_underrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1; tick(3);

    // Single byte both ways
    tx_push(8'hA5);
    check("t1_txrdy_full", tx_ready, 0);
    u0 = und_cnt; m_out[0] = 8'h3C;
    frame(1, 0, 0, 0, 8'h00);
    check("t1_miso", m_in[0], 8'hA5);
    check("t1_rxdata", rx_data, 8'h3C);
    check("t1_rxvld", rx_valid, 1);
    check("t1_txrdy", tx_ready, 1);
    check("t1_und", und_cnt - u0, 0);
    tick(5);
    check("t1_rxvld_hold", rx_valid, 1);
    rx_ready = 1; tick(1); rx_ready = 0;
    check("t1_rxvld_clr", rx_valid, 0);

    // Back-to-back, underrun on second byte
    tx_push(8'h12);
    u0 = und_cnt; o0 = ovr_cnt; q0 = rx_q.size();
    m_out[0] = 8'h01; m_out[1] = 8'h02; rx_ready = 1;
    frame(2, 0, 0, 0, 8'h00);
    rx_ready = 0;
    check("t2_miso0", m_in[0], 8'h12);
    check("t2_miso1", m_in[1], 8'hFF);
    check("t2_und", und_cnt - u0, 1);
    check("t2_ovr", ovr_cnt - o0, 0);
    check("t2_rxn", rx_q.size() - q0, 2);
    if (rx_q.size() >= q0 + 2) begin
      check("t2_rx0", rx_q[q0], 8'h01);
      check("t2_rx1", rx_q[q0 + 1], 8'h02);
    end

    // RX overrun
    o0 = ovr_cnt; u0 = und_cnt;
    m_out[0] = 8'h55; m_out[1] = 8'hAA;
    frame(2, 0, 0, 0, 8'h00);
    check("t3_rxdata", rx_data, 8'h55);
    check("t3_rxvld", rx_valid, 1);
    check("t3_ovr", ovr_cnt - o0, 1);
    check("t3_und", und_cnt - u0, 2);
    rx_ready = 1; tick(1); rx_ready = 0;

    // Aborted frame, then a clean one
    m_out[0] = 8'hFF;
    frame(1, 5, 0, 0, 8'h00);
    check("t4_norx", rx_valid, 0);
    m_out[0] = 8'hC3;
    frame(1, 0, 0, 0, 8'h00);
    check("t4_rxdata", rx_data, 8'hC3);
    check("t4_rxvld", rx_valid, 1);
    rx_ready = 1; tick(1); rx_ready = 0;

    // Accept coinciding with byte completion
    m_out[0] = 8'h5A;
    frame(1, 0, 0, 0, 8'h00);
    o0 = ovr_cnt; q0 = rx_q.size();
    m_out[0] = 8'h96;
    frame(1, 0, 1, 0, 8'h00);
    check("t5_rxvld", rx_valid, 1);
    check("t5_rxdata", rx_data, 8'h96);
    check("t5_ovr", ovr_cnt - o0, 0);
    check("t5_acc_n", rx_q.size() - q0, 1);
    if (rx_q.size() > q0) check("t5_acc_old", rx_q[q0], 8'h5A);
    rx_ready = 1; tick(1); rx_ready = 0;

    // TX write in the CS-fall load cycle
    check("t6_txrdy0", tx_ready, 1);
    u0 = und_cnt; m_out[0] = 8'h00;
    frame(1, 0, 0, 1, 8'h7E);
    check("t6_miso_idle", m_in[0], 8'hFF);
    check("t6_und", und_cnt - u0, 1);
    check("t6_txrdy_full", tx_ready, 0);
    u0 = und_cnt;
    frame(1, 0, 0, 0, 8'h00);
    check("t6_miso_next", m_in[0], 8'h7E);
    check("t6_und_next", und_cnt - u0, 0);
    rx_ready = 1; tick(1); rx_ready = 0;

    // Randomized frames against the holding-register model
    rx_ready = 1; tick(2);
    for (int it = 0; it < 8; it++) begin
      mdl_hv = 1'b0; mdl_hd = 8'h00; exp_und = 0;
      if ($urandom_range(0, 1) == 1) begin
        mdl_hd = 8'($urandom); mdl_hv = 1'b1; tx_push(mdl_hd);
      end
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) m_out[b] = 8'($urandom);
      u0 = und_cnt; q0 = rx_q.size();
      frame(nb, 0, 0, 0, 8'h00);
      for (int b = 0; b < nb; b++) begin
        exp_b = mdl_hv ? mdl_hd : 8'hFF;
        if (!mdl_hv) exp_und++;
        mdl_hv = 1'b0;
        check($sformatf("rnd%0d_miso%0d", it, b), m_in[b], exp_b);
        if (rx_q.size() > q0 + b) check($sformatf("rnd%0d_rx%0d", it, b), rx_q[q0 + b], m_out[b]);
        else check($sformatf("rnd%0d_rxmiss%0d", it, b), rx_q.size(), q0 + b + 1);
      end
      check($sformatf("rnd%0d_und", it), und_cnt - u0, exp_und);
    end
    rx_ready = 0;

    // Reset mid-frame
    tx_push(8'h33);
    spi_cs = 0; spi_mosi = 1; tick(6);
    for (int i = 0; i < 3; i++) begin spi_clk = 1; tick(4); spi_clk = 0; tick(4); end
    rst_n = 1'b0; #1;
    check("t7_busy", busy, 0);
    check("t7_oe", spi_miso_oe, 0);
    check("t7_miso", spi_miso, 1);
    check("t7_txrdy", tx_ready, 1);
    check("t7_rxvld", rx_valid, 0);
    tick(2); rst_n = 1'b1; tick(2);
    for (int i = 0; i < DW; i++) begin spi_clk = 1; tick(4); spi_clk = 0; tick(4); end
    check("t7_post_busy", busy, 0);
    check("t7_post_rxvld", rx_valid, 0);
    check("t7_post_oe", spi_miso_oe, 0);
    spi_cs = 1; tick(6);
    m_out[0] = 8'hE7;
    frame(1, 0, 0, 0, 8'h00);
    check("t7_rxdata", rx_data, 8'hE7);
    check("t7_rxvld_new", rx_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
